// File: rtl/ptr_pkg.sv
// Shared definitions for the CPU pointer register: operation codes and
// elaboration-time parameter validation.
package ptr_pkg;

    typedef enum logic [3:0] {
        NOP     = 4'd0,
        LOAD    = 4'd1,
        WR_LANE = 4'd2,
        INC     = 4'd3,
        DEC     = 4'd4,
        ADD_REL = 4'd5,
        ADD_LO  = 4'd6,
        ADD_HI  = 4'd7,
        SAVE    = 4'd8,
        RESTORE = 4'd9
    } ptr_op_e;

    // The relative add always splits at bit 8, so the register must be wider than a byte.
    function automatic bit ptr_cfg_ok(input int width, input int lane);
        return (lane > 0) && (width % lane == 0) && (width >= 2 * lane) && (width > 8);
    endfunction

endpackage

// File: rtl/ptr_lo_adder.sv
// Byte adder for the low part of relative adds; reports the carries out of
// bit 3 (half carry) and bit 7 (carry).
module ptr_lo_adder (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] sum_o,
    output logic       h_o,
    output logic       c_o
);

    logic [8:0] full;
    logic [4:0] nib;

    assign full  = {1'b0, a_i} + {1'b0, b_i};
    assign nib   = {1'b0, a_i[3:0]} + {1'b0, b_i[3:0]};
    assign sum_o = full[7:0];
    assign h_o   = nib[4];
    assign c_o   = full[8];

endmodule

// File: rtl/ptr_register.sv
// Parametrised CPU pointer register (PC/SP): loads, lane writes, inc/dec,
// one- or two-cycle signed relative add, shadow copy and one-shot INC inhibit.
module ptr_register
    import ptr_pkg::*;
#(
    parameter int              WIDTH       = 16,
    parameter int              LANE        = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cpu_en,
    input  ptr_op_e                         op,
    input  logic [WIDTH-1:0]                wdata,
    input  logic [LANE-1:0]                 wdata_lane,
    input  logic [$clog2(WIDTH/LANE)-1:0]   lane_sel,
    input  logic [7:0]                      offset,
    input  logic                            inhibit_arm,
    output logic [WIDTH-1:0]                ptr,
    output logic                            flag_h,
    output logic                            flag_c,
    output logic                            add_pending
);

    localparam int NLANES = WIDTH / LANE;
    localparam int SEL_W  = $clog2(NLANES);
    localparam int HI_W   = WIDTH - 8;

    if (!ptr_cfg_ok(WIDTH, LANE)) begin : g_bad_cfg
        $error("ptr_register: WIDTH must be a multiple of LANE, at least 2*LANE and wider than 8");
    end

    logic [WIDTH-1:0] ptr_q, ptr_d, shadow_q, shadow_d;
    logic             flag_h_q, flag_h_d, flag_c_q, flag_c_d;
    logic             pend_q, pend_d, carry_q, carry_d, sign_q, sign_d;
    logic             inhibit_q, inhibit_d;

    logic [7:0]       lo_sum;
    logic             lo_h, lo_c;

    // Upper part gets the low-byte carry plus the sign extension of the offset.
    function automatic logic [HI_W-1:0] hi_add(input logic [HI_W-1:0] hi,
                                               input logic cin, input logic sgn);
        return hi + HI_W'(cin) + (sgn ? {HI_W{1'b1}} : {HI_W{1'b0}});
    endfunction

    ptr_lo_adder u_lo_adder (
        .a_i   (ptr_q[7:0]),
        .b_i   (offset),
        .sum_o (lo_sum),
        .h_o   (lo_h),
        .c_o   (lo_c)
    );

    always_comb begin
        ptr_d     = ptr_q;
        shadow_d  = shadow_q;
        flag_h_d  = flag_h_q;
        flag_c_d  = flag_c_q;
        pend_d    = pend_q;
        carry_d   = carry_q;
        sign_d    = sign_q;
        inhibit_d = inhibit_q;
        if (cpu_en) begin
            case (op)
                LOAD:    ptr_d = wdata;
                WR_LANE: begin
                    for (int i = 0; i < NLANES; i++) begin
                        if (lane_sel == SEL_W'(i)) ptr_d[i*LANE +: LANE] = wdata_lane;
                    end
                end
                INC: begin
                    if (inhibit_q) inhibit_d = 1'b0;
                    else           ptr_d     = ptr_q + WIDTH'(1);
                end
                DEC:     ptr_d = ptr_q - WIDTH'(1);
                ADD_REL: begin
                    ptr_d    = {hi_add(ptr_q[WIDTH-1:8], lo_c, offset[7]), lo_sum};
                    flag_h_d = lo_h;
                    flag_c_d = lo_c;
                end
                ADD_LO: begin
                    ptr_d[7:0] = lo_sum;
                    flag_h_d   = lo_h;
                    flag_c_d   = lo_c;
                    carry_d    = lo_c;
                    sign_d     = offset[7];
                    pend_d     = 1'b1;
                end
                ADD_HI: begin
                    ptr_d[WIDTH-1:8] = hi_add(ptr_q[WIDTH-1:8], carry_q, sign_q);
                    carry_d          = 1'b0;
                    sign_d           = 1'b0;
                    pend_d           = 1'b0;
                end
                SAVE:    shadow_d = ptr_q;
                RESTORE: ptr_d    = shadow_q;
                default: ;
            endcase
            // Arming wins over a same-cycle clear so the next INC is still suppressed.
            if (inhibit_arm) inhibit_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q     <= RESET_VALUE;
            shadow_q  <= RESET_VALUE;
            flag_h_q  <= 1'b0;
            flag_c_q  <= 1'b0;
            pend_q    <= 1'b0;
            carry_q   <= 1'b0;
            sign_q    <= 1'b0;
            inhibit_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            shadow_q  <= shadow_d;
            flag_h_q  <= flag_h_d;
            flag_c_q  <= flag_c_d;
            pend_q    <= pend_d;
            carry_q   <= carry_d;
            sign_q    <= sign_d;
            inhibit_q <= inhibit_d;
        end
    end

    assign ptr         = ptr_q;
    assign flag_h      = flag_h_q;
    assign flag_c      = flag_c_q;
    assign add_pending = pend_q;

endmodule

// File: tb/tb_ptr_register.sv
// Directed bench for ptr_register: a 16-bit instance (reset 0x0100) driven from
// a vector table, plus hand sequences for async reset and a 24-bit instance.
module tb_ptr_register;
    import ptr_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en16 = 1'b0, en24 = 1'b0;
    ptr_op_e     op = NOP;
    logic [15:0] wd16 = '0;
    logic [23:0] wd24 = '0;
    logic [7:0]  lane = '0;
    logic        sel16 = 1'b0;
    logic [1:0]  sel24 = '0;
    logic [7:0]  off = '0;
    logic        arm = 1'b0;

    logic [15:0] p16;
    logic        h16, c16, pd16;
    logic [23:0] p24;
    logic        h24, c24, pd24;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ptr_register #(.WIDTH(16), .LANE(8), .RESET_VALUE(16'h0100)) dut16 (
        .clk(clk), .reset(reset), .cpu_en(en16), .op(op), .wdata(wd16),
        .wdata_lane(lane), .lane_sel(sel16), .offset(off), .inhibit_arm(arm),
        .ptr(p16), .flag_h(h16), .flag_c(c16), .add_pending(pd16)
    );

    ptr_register #(.WIDTH(24), .LANE(8), .RESET_VALUE(24'h000000)) dut24 (
        .clk(clk), .reset(reset), .cpu_en(en24), .op(op), .wdata(wd24),
        .wdata_lane(lane), .lane_sel(sel24), .offset(off), .inhibit_arm(arm),
        .ptr(p24), .flag_h(h24), .flag_c(c24), .add_pending(pd24)
    );

    typedef struct {
        ptr_op_e     op;
        logic [15:0] wd;
        logic [7:0]  lane;
        logic        sel;
        logic [7:0]  off;
        logic        arm;
        logic        en;
        logic [15:0] ep;
        logic        eh, ec, epd;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t v(ptr_op_e o, logic [15:0] w, logic [7:0] l, logic s,
                               logic [7:0] f, logic a, logic e, logic [15:0] p,
                               logic h, logic c, logic pd);
        vec_t r;
        r.op = o; r.wd = w; r.lane = l; r.sel = s; r.off = f; r.arm = a; r.en = e;
        r.ep = p; r.eh = h; r.ec = c; r.epd = pd;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] ep,
                           input logic eh, input logic ec, input logic epd);
        check({name, " ptr"}, 32'(p16), 32'(ep));
        check({name, " h"},   32'(h16), 32'(eh));
        check({name, " c"},   32'(c16), 32'(ec));
        check({name, " pend"}, 32'(pd16), 32'(epd));
    endtask

    task automatic step16(input ptr_op_e o, input logic [15:0] w, input logic [7:0] l,
                          input logic s, input logic [7:0] f, input logic a, input logic e);
        op = o; wd16 = w; lane = l; sel16 = s; off = f; arm = a; en16 = e; en24 = 1'b0;
        @(posedge clk);
        #1;
        op = NOP; arm = 1'b0; en16 = 1'b0;
    endtask

    task automatic step24(input ptr_op_e o, input logic [23:0] w, input logic [7:0] l,
                          input logic [1:0] s, input logic [7:0] f);
        op = o; wd24 = w; lane = l; sel24 = s; off = f; arm = 1'b0; en24 = 1'b1; en16 = 1'b0;
        @(posedge clk);
        #1;
        op = NOP; en24 = 1'b0;
    endtask

    initial begin
        //            op        wdata     lane   sel  off    arm en  ptr       h  c  pend
        tv.push_back(v(INC,     16'h0000, 8'h00, 0, 8'h00, 0, 1, 16'h0101, 0, 0, 0));
        tv.push_back(v(INC,     16'h0000, 8'h00, 0, 8'h00, 0, 1, 16'h0102, 0, 0, 0));
        tv.push_back(v(INC,     16'h0000, 8'h00, 0, 8'h00, 0, 1, 16'h0103, 0, 0, 0));
        tv.push_back(v(LOAD,    16'hFFFF, 8'h00, 0, 8'h00, 0, 1, 16'hFFFF, 0, 0, 0));
        tv.push_back(v(INC,     16'h0000, 8'h00, 0, 8'h00, 0, 1, 16'h0000, 0, 0, 0));
        tv.push_back(v(DEC,     16'h0000, 8'h00, 0, 8'h00, 0, 1, 16'hFFFF, 0, 0, 0));
        tv.push_back(v(WR_LANE, 16'h0000, 8'h12, 1, 8'h00, 0, 1, 16'h12FF, 0, 0, 0));
        tv.push_back(v(WR_LANE, 16'h0000, 8'h34, 0, 8'h00, 0, 1, 16'h1234, 0, 0, 0));
        tv.push_back(v(LOAD,    16'hFFF8, 8'h00, 0, 8'h00, 0, 1, 16'hFFF8, 0, 0, 0));
        tv.push_back(v(ADD_REL, 16'h0000, 8'h00, 0, 8'h08, 0, 1, 16'h0000, 1, 1, 0));
        tv.push_back(v(LOAD,    16'h0005, 8'h00, 0, 8'h00, 0, 1, 16'h0005, 1, 1, 0));
        tv.push_back(v(ADD_REL, 16'h0000, 8'h00, 0, 8'hFE, 0, 1, 16'h0003, 1, 1, 0));
        tv.push_back(v(ADD_REL, 16'h0000, 8'h00, 0, 8'h01, 0, 1, 16'h0004, 0, 0, 0));
        tv.push_back(v(DEC,     16'h0000, 8'h00, 0, 8'h00, 0, 1, 16'h0003, 0, 0, 0));
        tv.push_back(v(ADD_REL, 16'h0000, 8'h00, 0, 8'h80, 0, 1, 16'hFF83, 0, 0, 0));
        tv.push_back(v(LOAD,    16'h12F0, 8'h00, 0, 8'h00, 0, 1, 16'h12F0, 0, 0, 0));
        tv.push_back(v(ADD_LO,  16'h0000, 8'h00, 0, 8'h20, 0, 1, 16'h1210, 0, 1, 1));
        tv.push_back(v(NOP,     16'h0000, 8'h00, 0, 8'h00, 0, 1, 16'h1210, 0, 1, 1));
        tv.push_back(v(ADD_HI,  16'h0000, 8'h00, 0, 8'h00, 0, 0, 16'h1210, 0, 1, 1));
        tv.push_back(v(ADD_HI,  16'h0000, 8'h00, 0, 8'h00, 0, 1, 16'h1310, 0, 1, 0));
        tv.push_back(v(ADD_HI,  16'h0000, 8'h00, 0, 8'h00, 0, 1, 16'h1310, 0, 1, 0));
        tv.push_back(v(LOAD,    16'h0040, 8'h00, 0, 8'h00, 0, 1, 16'h0040, 0, 1, 0));
        tv.push_back(v(NOP,     16'h0000, 8'h00, 0, 8'h00, 1, 1, 16'h0040, 0, 1, 0));
        tv.push_back(v(INC,     16'h0000, 8'h00, 0, 8'h00, 0, 1, 16'h0040, 0, 1, 0));
        tv.push_back(v(INC,     16'h0000, 8'h00, 0, 8'h00, 0, 1, 16'h0041, 0, 1, 0));
        tv.push_back(v(INC,     16'h0000, 8'h00, 0, 8'h00, 1, 1, 16'h0042, 0, 1, 0));
        tv.push_back(v(INC,     16'h0000, 8'h00, 0, 8'h00, 0, 1, 16'h0042, 0, 1, 0));
        tv.push_back(v(INC,     16'h0000, 8'h00, 0, 8'h00, 0, 1, 16'h0043, 0, 1, 0));
        tv.push_back(v(LOAD,    16'hAAAA, 8'h00, 0, 8'h00, 0, 0, 16'h0043, 0, 1, 0));
        tv.push_back(v(INC,     16'h0000, 8'h00, 0, 8'h00, 0, 0, 16'h0043, 0, 1, 0));
        tv.push_back(v(LOAD,    16'hC000, 8'h00, 0, 8'h00, 0, 1, 16'hC000, 0, 1, 0));
        tv.push_back(v(SAVE,    16'h0000, 8'h00, 0, 8'h00, 0, 1, 16'hC000, 0, 1, 0));
        tv.push_back(v(LOAD,    16'h0040, 8'h00, 0, 8'h00, 0, 1, 16'h0040, 0, 1, 0));
        tv.push_back(v(INC,     16'h0000, 8'h00, 0, 8'h00, 0, 1, 16'h0041, 0, 1, 0));
        tv.push_back(v(RESTORE, 16'h0000, 8'h00, 0, 8'h00, 0, 1, 16'hC000, 0, 1, 0));
        tv.push_back(v(ptr_op_e'(4'hF), 16'h5555, 8'h00, 0, 8'h00, 0, 1, 16'hC000, 0, 1, 0));
        tv.push_back(v(ADD_LO,  16'h0000, 8'h00, 0, 8'hF0, 0, 1, 16'hC0F0, 0, 0, 1));
        tv.push_back(v(INC,     16'h0000, 8'h00, 0, 8'h00, 0, 1, 16'hC0F1, 0, 0, 1));
        tv.push_back(v(ADD_HI,  16'h0000, 8'h00, 0, 8'h00, 0, 1, 16'hBFF1, 0, 0, 0));
        tv.push_back(v(LOAD,    16'h12F0, 8'h00, 0, 8'h00, 0, 1, 16'h12F0, 0, 0, 0));
        tv.push_back(v(ADD_LO,  16'h0000, 8'h00, 0, 8'h20, 0, 1, 16'h1210, 0, 1, 1));

        // Reset away from any clock edge.
        #1 reset = 1'b1;
        #2;
        check16("reset", 16'h0100, 1'b0, 1'b0, 1'b0);
        check("reset24 ptr", 32'(p24), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        foreach (tv[i]) begin
            step16(tv[i].op, tv[i].wd, tv[i].lane, tv[i].sel, tv[i].off, tv[i].arm, tv[i].en);
            check16($sformatf("vec%0d", i), tv[i].ep, tv[i].eh, tv[i].ec, tv[i].epd);
        end

        // Split add interrupted by an asynchronous reset mid-cycle.
        #2 reset = 1'b1;
        #1;
        check16("async_reset", 16'h0100, 1'b0, 1'b0, 1'b0);
        #1 reset = 1'b0;
        step16(ADD_HI, 16'h0, 8'h0, 1'b0, 8'h0, 1'b0, 1'b1);
        check16("hi_after_reset", 16'h0100, 1'b0, 1'b0, 1'b0);

        // Reset must also drop an armed inhibit.
        step16(NOP, 16'h0, 8'h0, 1'b0, 8'h0, 1'b1, 1'b1);
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        step16(INC, 16'h0, 8'h0, 1'b0, 8'h0, 1'b0, 1'b1);
        check16("inc_after_reset", 16'h0101, 1'b0, 1'b0, 1'b0);

        // 24-bit instance.
        step24(LOAD, 24'hC00000, 8'h00, 2'd0, 8'h00);
        check("w24 load", 32'(p24), 32'hC00000);
        step24(SAVE, 24'h0, 8'h00, 2'd0, 8'h00);
        step24(LOAD, 24'h000040, 8'h00, 2'd0, 8'h00);
        step24(INC, 24'h0, 8'h00, 2'd0, 8'h00);
        check("w24 inc", 32'(p24), 32'h000041);
        step24(RESTORE, 24'h0, 8'h00, 2'd0, 8'h00);
        check("w24 restore", 32'(p24), 32'hC00000);
        step24(WR_LANE, 24'h0, 8'h5A, 2'd2, 8'h00);
        check("w24 lane2", 32'(p24), 32'h5A0000);
        step24(WR_LANE, 24'h0, 8'h77, 2'd3, 8'h00);
        check("w24 lane3 ignored", 32'(p24), 32'h5A0000);
        step24(ADD_REL, 24'h0, 8'h00, 2'd0, 8'hFF);
        check("w24 addrel", 32'(p24), 32'h59FFFF);
        check("w24 addrel c", 32'(c24), 32'h0);
        step24(LOAD, 24'h00FFF0, 8'h00, 2'd0, 8'h00);
        step24(ADD_LO, 24'h0, 8'h00, 2'd0, 8'h10);
        check("w24 addlo", 32'(p24), 32'h00FF00);
        check("w24 addlo pend", 32'(pd24), 32'h1);
        check("w24 addlo h", 32'(h24), 32'h0);
        step24(ADD_HI, 24'h0, 8'h00, 2'd0, 8'h00);
        check("w24 addhi", 32'(p24), 32'h010000);
        check("w24 addhi pend", 32'(pd24), 32'h0);
        check("w24 flag c held", 32'(c24), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
